// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Sweeps a register-file read port from x0 to x(NUM_REGS-1) after a start
// pulse, streams each value with its index over a valid/ready interface and
// reports the XOR checksum of the accepted beats when the sweep completes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a sweep (IDLE only) / cancel a running sweep
//   rf_rs, rf_rd       register-file read select and combinational read data
//   out_valid/ready    beat handshake
//   out_data, out_idx  register value and its index
//   out_last           beat carries index NUM_REGS-1
//   busy               sweep in progress
//   done               one-cycle pulse after the final beat is accepted
//   checksum           XOR of all beats of the last completed sweep
module regfile_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_rs,
  input  logic [XLEN-1:0]   rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   checksum
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [ADDR_W:0] PTR_END  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W + 1)'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   checksum_q, checksum_d;

  logic xfer;
  logic load;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;
    xfer        = out_valid_q && out_ready;
    load        = (!out_valid_q || out_ready) && (ptr_q < PTR_END);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          ptr_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      STREAM: begin
        if (abort) begin
          // Abort beats any concurrent transfer: nothing is accumulated.
          state_d     = IDLE;
          ptr_d       = '0;
          out_valid_d = 1'b0;
        end else begin
          if (xfer) begin
            acc_d = acc_q ^ out_data_q;
          end
          if (xfer && out_last_q) begin
            state_d     = IDLE;
            checksum_d  = acc_q ^ out_data_q;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
          end else if (load) begin
            out_data_d  = rf_rd;
            out_idx_d   = ptr_q[ADDR_W-1:0];
            out_last_d  = (ptr_q == PTR_LAST);
            out_valid_d = 1'b1;
            ptr_d       = ptr_q + 1'b1;
          end else if (xfer) begin
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign rf_rs     = (state_q == STREAM) ? ptr_q[ADDR_W-1:0] : '0;
  assign busy      = (state_q == STREAM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: randomized consumer back-pressure
// against a beat-level reference model of the sweep.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  rf_rs;
  logic [63:0] rf_rd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [63:0] checksum;

  logic [63:0] regs [32];

  always #5 clk = ~clk;

  assign rf_rd = (rf_rs == 5'd0) ? 64'd0 : regs[rf_rs];

  regfile_dump_reader #(
    .NUM_REGS(32),
    .XLEN    (64),
    .ADDR_W  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rf_rs    (rf_rs),
    .rf_rd    (rf_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sweep state at beat granularity.
  bit          m_busy  = 0;
  bit          m_done  = 0;
  bit          m_stall = 0;
  int          m_idx   = 0;
  int          m_beats = 0;
  int          done_count = 0;
  logic [63:0] m_acc   = '0;
  logic [63:0] m_cks   = '0;
  logic [63:0] held_data;
  logic [4:0]  held_idx;

  // Stimulus controls.
  int unsigned ready_pct  = 100;
  bit          start_req  = 0;
  bit          start_hold = 0;
  int          abort_idx  = -1;
  bit          stall3     = 0;
  int          stall_cnt  = 0;

  task automatic cycle();
    logic [63:0] exp_d;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("checksum", checksum, m_cks);
    if (m_done) done_count++;
    if (!m_busy) begin
      chk("valid_idle", 64'(out_valid), 64'd0);
      chk("rs_idle", 64'(rf_rs), 64'd0);
    end
    if (m_stall) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", out_data, held_data);
      chk("stall_idx", 64'(out_idx), 64'(held_idx));
    end
    m_done = 0;

    out_ready = ($urandom_range(99) < ready_pct);
    if (stall3 && out_valid && out_idx == 5'd3 && stall_cnt < 4) begin
      out_ready = 1'b0;
      stall_cnt++;
      if (stall_cnt == 2) regs[7] = 64'hDEAD_BEEF_0000_0007;
    end
    start     = start_req || (start_hold && m_busy);
    start_req = 0;
    abort     = (abort_idx >= 0) && m_busy && out_valid && (int'(out_idx) == abort_idx);
    if (abort) begin
      out_ready = 1'b1;
      abort_idx = -1;
    end

    if (m_busy) begin
      if (abort) begin
        m_busy  = 0;
        m_stall = 0;
      end else begin
        if (out_valid && out_ready) begin
          exp_d = (m_idx == 0) ? 64'd0 : regs[m_idx];
          chk("beat_idx", 64'(out_idx), 64'(m_idx));
          chk("beat_data", out_data, exp_d);
          chk("beat_last", 64'(out_last), 64'(m_idx == 31));
          m_acc = m_acc ^ exp_d;
          m_beats++;
          if (m_idx == 31) begin
            m_busy = 0;
            m_done = 1;
            m_cks  = m_acc;
            chk("beat_count", 64'(m_beats), 64'd32);
          end
          m_idx++;
        end
        m_stall   = out_valid && !out_ready;
        held_data = out_data;
        held_idx  = out_idx;
      end
    end else if (start) begin
      m_busy  = 1;
      m_idx   = 0;
      m_acc   = '0;
      m_beats = 0;
      m_stall = 0;
    end
  endtask

  task automatic run_until_idle();
    int unsigned n = 0;
    cycle();
    while ((m_busy || m_done) && n < 3000) begin
      cycle();
      n++;
    end
    if (n >= 3000) chk("sweep_timeout", 64'd0, 64'd1);
    cycle();
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(i);
  endtask

  logic [63:0] pre_cks;
  int          dc0;
  int unsigned n_wait;

  initial begin
    preload();
    pre_cks = '0;
    for (int i = 1; i < 32; i++) pre_cks = pre_cks ^ (64'h1111_0000_0000_0000 + 64'(i));
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_checksum", checksum, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_rs", 64'(rf_rs), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-rate sweep.
    ready_pct = 100; start_req = 1; run_until_idle();
    chk("sweep1_cks", checksum, pre_cks);

    // Random back-pressure.
    ready_pct = 50; start_req = 1; dc0 = done_count; run_until_idle();
    chk("sweep2_cks", checksum, pre_cks);
    chk("sweep2_dones", 64'(done_count - dc0), 64'd1);

    // start held high for the whole sweep.
    ready_pct = 70; start_req = 1; start_hold = 1; dc0 = done_count; run_until_idle();
    start_hold = 0;
    chk("hold_dones", 64'(done_count - dc0), 64'd1);
    repeat (3) cycle();

    // Abort while beat 10 is pending.
    ready_pct = 100; abort_idx = 10; start_req = 1; run_until_idle();
    repeat (3) cycle();
    chk("abort_cks", checksum, pre_cks);

    // Reset mid-sweep.
    ready_pct = 100; start_req = 1; n_wait = 0;
    while (m_beats < 6 && n_wait < 200) begin cycle(); n_wait++; end
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_idx", 64'(out_idx), 64'd0);
    chk("mrst_last", 64'(out_last), 64'd0);
    chk("mrst_checksum", checksum, 64'd0);
    chk("mrst_rs", 64'(rf_rs), 64'd0);
    m_busy = 0; m_done = 0; m_stall = 0; m_cks = '0;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_req = 1; run_until_idle();
    chk("post_rst_cks", checksum, pre_cks);

    // x7 rewritten while beat 3 stalls.
    ready_pct = 100; stall3 = 1; stall_cnt = 0; start_req = 1; run_until_idle();
    stall3 = 0;
    chk("x7_cks", checksum, pre_cks ^ (64'h1111_0000_0000_0007) ^ 64'hDEAD_BEEF_0000_0007);

    // Random mix.
    preload();
    for (int s = 0; s < 3; s++) begin
      ready_pct = $urandom_range(90, 20); start_req = 1; run_until_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
